reg_file_resp: RTL and testbench

Register-file responder serving the decode stage's register interface: two synchronous read ports, one write-back port, and a pending-write scoreboard. It answers the decode stage's read-address requests with registered operand data, absorbs write-back data, and flags read-after-write hazards for the pipeline. After reset it runs a zero-clear sweep over all registers before accepting traffic.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/rf_scoreboard.sv | 47 ++++
 rtl/reg_file_resp.sv | 115 +++++++++++
 tb/tb_reg_file_resp.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared register-file parameters and state type
package riscv_pkg;
    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = REG_AW + 1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-write scoreboard with read-after-write hazard lookup
module rf_scoreboard
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              upd_en,
    input  logic              lookup_en,
    input  logic              issue_en,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [REG_AW-1:0] rd_addr1,
    input  logic [REG_AW-1:0] rd_addr2,
    output logic              hazard1,
    output logic              hazard2
);
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    // Issue is applied after write-back so a newer producer keeps the bit set.
    always_comb begin
        pending_nxt = pending;
        if (flush) begin
            pending_nxt = '0;
        end else if (upd_en) begin
            if (wr_en)
                pending_nxt[wr_addr] = 1'b0;
            if (issue_en && (issue_rd != '0))
                pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

    assign hazard1 = lookup_en && (rd_addr1 != '0) &&
                     (pending[rd_addr1] || (issue_en && (issue_rd == rd_addr1)));
    assign hazard2 = lookup_en && (rd_addr2 != '0) &&
                     (pending[rd_addr2] || (issue_en && (issue_rd == rd_addr2)));
endmodule

// File: rtl/reg_file_resp.sv
// rtl/reg_file_resp.sv - two-read one-write register file with zero-clear sweep and hazard flags
module reg_file_resp
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_req,
    output logic              ready,
    input  logic              rd_en,
    input  logic [REG_AW-1:0] rd_addr1,
    input  logic [REG_AW-1:0] rd_addr2,
    output logic [XLEN-1:0]   rd_data1,
    output logic [XLEN-1:0]   rd_data2,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              issue_en,
    input  logic [REG_AW-1:0] issue_rd,
    output logic              hazard1,
    output logic              hazard2
);
    rf_state_t        state;
    rf_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sweep_we;
    logic             live;
    logic             wr_ok;
    logic             rd_ok;
    logic [XLEN-1:0]  rd1_nxt;
    logic [XLEN-1:0]  rd2_nxt;
    logic [XLEN-1:0]  regs [NREG];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sweep_we  = 1'b0;
        if (clear_req) begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
        end else if (state == CLEAR) begin
            sweep_we = 1'b1;
            cnt_nxt  = cnt + 1'b1;
            if (cnt == CNT_W'(NREG - 1))
                state_nxt = READY;
        end
    end

    assign ready = (state == READY);
    // A clear request pre-empts any traffic presented in the same cycle.
    assign live  = ready && !clear_req;
    assign wr_ok = live && wr_en && (wr_addr != '0);
    assign rd_ok = live && rd_en;

    always_ff @(posedge clk) begin
        if (sweep_we)
            regs[cnt[REG_AW-1:0]] <= '0;
        else if (wr_ok)
            regs[wr_addr] <= wr_data;
    end

    always_comb begin
        rd1_nxt = regs[rd_addr1];
        rd2_nxt = regs[rd_addr2];
        if (rd_addr1 == '0)
            rd1_nxt = '0;
        else if (wr_ok && (wr_addr == rd_addr1))
            rd1_nxt = wr_data;
        if (rd_addr2 == '0)
            rd2_nxt = '0;
        else if (wr_ok && (wr_addr == rd_addr2))
            rd2_nxt = wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            rd_data1 <= '0;
            rd_data2 <= '0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) begin
                rd_data1 <= rd1_nxt;
                rd_data2 <= rd2_nxt;
            end
        end
    end

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     ((state == CLEAR) || clear_req),
        .upd_en    (live),
        .lookup_en (ready),
        .issue_en  (issue_en),
        .issue_rd  (issue_rd),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .hazard1   (hazard1),
        .hazard2   (hazard2)
    );
endmodule

// File: tb/tb_reg_file_resp.sv
// tb/tb_reg_file_resp.sv - scoreboard bench for reg_file_resp against a register-level model
module tb_reg_file_resp;
    logic        clk;
    logic        reset_n;
    logic        clear_req;
    logic        ready;
    logic        rd_en;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        rd_valid;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        hazard1;
    logic        hazard2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [63:0] last_data = '0;

    logic [31:0] mregs [32];
    logic        mpend [32];
    logic        mready;
    int          sweep_left;

    reg_file_resp dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_req (clear_req),
        .ready     (ready),
        .rd_en     (rd_en),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .rd_valid  (rd_valid),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .issue_en  (issue_en),
        .issue_rd  (issue_rd),
        .hazard1   (hazard1),
        .hazard2   (hazard2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sweep_left = 32;
        mready     = 1'b0;
        for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
    endtask

    function automatic logic model_hazard(input logic [4:0] a, input logic ie, input logic [4:0] ir);
        return mready && (a != 0) && (mpend[a] || (ie && (ir == a)));
    endfunction

    // Drive one cycle of inputs, check combinational outputs, then advance the model across the edge.
    task automatic do_cycle(input logic clr, input logic rde, input logic [4:0] a1, input logic [4:0] a2,
                            input logic we, input logic [4:0] wa, input logic [31:0] wd,
                            input logic ie, input logic [4:0] ir);
        logic [31:0] e1, e2;
        clear_req = clr; rd_en = rde; rd_addr1 = a1; rd_addr2 = a2;
        wr_en = we; wr_addr = wa; wr_data = wd; issue_en = ie; issue_rd = ir;
        #2;
        check("ready", ready, mready);
        check("hazard1", hazard1, model_hazard(a1, ie, ir));
        check("hazard2", hazard2, model_hazard(a2, ie, ir));
        if (clr) begin
            model_reset();
        end else if (!mready) begin
            sweep_left--;
            if (sweep_left == 0) begin
                mready = 1'b1;
                for (int i = 0; i < 32; i++) mregs[i] = '0;
            end
        end else begin
            if (rde) begin
                e1 = (a1 == 0) ? 32'h0 : ((we && wa == a1) ? wd : mregs[a1]);
                e2 = (a2 == 0) ? 32'h0 : ((we && wa == a2) ? wd : mregs[a2]);
                exp_q.push_back({e1, e2});
            end
            if (we && wa != 0) mregs[wa] = wd;
            if (we) mpend[wa] = 1'b0;
            if (ie && ir != 0) mpend[ir] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pulse_reset();
        clear_req = 0; rd_en = 0; wr_en = 0; issue_en = 0;
        reset_n = 1'b0;
        #1;
        check("rst_ready", ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", {rd_data1, rd_data2}, 64'h0);
        check("rst_hazards", {hazard1, hazard2}, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset_n) begin
            last_data = '0;
            check("rst_mon_valid", rd_valid, 0);
            check("rst_mon_data", {rd_data1, rd_data2}, 64'h0);
        end else if (rd_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_valid_unexpected: got rd_valid=1 expected no outstanding read at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                n_checks--;
                check("rd_data", {rd_data1, rd_data2}, e);
                last_data = e;
            end
        end else begin
            check("rd_hold", {rd_data1, rd_data2}, last_data);
        end
    end

    initial begin
        reset_n = 1'b0;
        clear_req = 0; rd_en = 0; rd_addr1 = 0; rd_addr2 = 0;
        wr_en = 0; wr_addr = 0; wr_data = 0; issue_en = 0; issue_rd = 0;
        for (int i = 0; i < 32; i++) mregs[i] = 'x;
        model_reset();
        #2;
        check("init_ready", ready, 0);
        check("init_rd_valid", rd_valid, 0);
        check("init_rd_data", {rd_data1, rd_data2}, 64'h0);
        check("init_hazards", {hazard1, hazard2}, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // ready must stay low for exactly 32 edges after release
        repeat (32) idle_cycle();

        for (int i = 1; i < 32; i++) do_cycle(0, 1, 5'(i), 5'(32 - i), 0, 0, 0, 0, 0);

        do_cycle(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        do_cycle(0, 1, 5, 0, 0, 0, 0, 0, 0);
        idle_cycle();
        do_cycle(0, 1, 1, 7, 1, 7, 32'h12345678, 0, 0);
        do_cycle(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
        do_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);

        // scoreboard: issue x9, hold, write back, then simultaneous issue+write
        do_cycle(0, 1, 9, 0, 0, 0, 0, 1, 9);
        repeat (3) do_cycle(0, 1, 9, 9, 0, 0, 0, 0, 0);
        do_cycle(0, 1, 9, 0, 1, 9, 32'h00000909, 0, 0);
        do_cycle(0, 1, 9, 0, 0, 0, 0, 0, 0);
        do_cycle(0, 1, 9, 0, 1, 9, 32'h11110909, 1, 9);
        do_cycle(0, 1, 9, 2, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 9, 0, 1, 9, 32'h22220909, 0, 0);
        do_cycle(0, 0, 9, 0, 0, 0, 0, 1, 0);

        // clear with x3 loaded and pending
        do_cycle(0, 0, 3, 0, 1, 3, 32'hA5A5A5A5, 1, 3);
        do_cycle(1, 0, 3, 3, 0, 0, 0, 0, 0);
        repeat (32) do_cycle(0, 1, 3, 3, 1, 3, 32'h5A5A5A5A, 1, 3);
        do_cycle(0, 1, 3, 9, 0, 0, 0, 0, 0);

        // reset mid-sweep
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (10) idle_cycle();
        pulse_reset();
        repeat (32) idle_cycle();
        do_cycle(0, 1, 3, 5, 0, 0, 0, 0, 0);

        for (int k = 0; k < 400; k++) begin
            do_cycle($urandom_range(0, 99) == 0,
                     $urandom_range(0, 9) < 6,
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                     $urandom_range(0, 1) == 1,
                     5'($urandom_range(0, 7)), $urandom,
                     $urandom_range(0, 9) < 3,
                     5'($urandom_range(0, 7)));
        end

        repeat (3) idle_cycle();
        check("reads_outstanding", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
